ddr5_cmd_sequencer: RTL and testbench
=====================================

// Module: ddr5_cmd_sequencer
// PURPOSE
//  Closed-page DDR5 command sequencer, directly downstream of the parsed-request scheduler queue.
//  Pops one decoded request at a time (valid/ready) and emits the timed command sequence
//  ACT0,ACT1,RD0/WR0,RD1/WR1,PRE, enforcing tRCD, read/write-to-precharge and tRP.
//  Feeds the command output/trace writer; one request in flight, no reordering.
// PARAMETERS
//  T_RCD  8   cycles ACT0 -> RD0/WR0; legal >=2
//  T_RTP  6   cycles RD0 -> PRE; legal >=2
//  T_WTP  12  cycles WR0 -> PRE; legal >=2
//  T_RP   8   cycles PRE -> return to IDLE (req_ready high); legal >=1
//  CNT_W  8   wait-counter width; every T_* must be < 2**CNT_W
// PORTS
//  clk            in   1   single clock
//  rst_n          in   1   async active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   sequencer accepts request this cycle
//  req_opn        in   2   0 data read, 1 write, 2 instr fetch (read), 3 illegal
//  req_bg         in   3   bank group
//  req_ba         in   2   bank
//  req_row        in   16  row
//  req_col        in   10  column {addr[17:12],addr[5:2]}
//  cmd_valid      out  1   command on cmd_* this cycle
//  cmd_type       out  3   0 NOP,1 ACT0,2 ACT1,3 RD0,4 RD1,5 WR0,6 WR1,7 PRE
//  cmd_bg         out  3   latched bank group
//  cmd_ba         out  2   latched bank
//  cmd_row        out  16  latched row
//  cmd_col        out  10  latched column
//  busy           out  1   state != IDLE
//  err_illegal_op out  1   one-cycle pulse: opn==3 request dropped
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset: state IDLE, counter 0, latched fields 0; cmd_valid=0, cmd_type=NOP, busy=0,
//   err_illegal_op=0; req_ready=1 once rst_n is high.
//  Handshake: req_ready = (state==IDLE). Transfer on rising edge with req_valid&&req_ready.
//   Fields are latched at transfer and held on cmd_bg/ba/row/col until the next transfer.
//  Outputs are Moore, decoded from the registered state. cmd_valid=1 only in ACT0, ACT1,
//   CAS0, CAS1 and PRE; cmd_type=NOP elsewhere.
//  FSM: IDLE -> ACT0 -> ACT1 -> WAIT_RCD -> CAS0 -> CAS1 -> WAIT_PRE -> PRE -> WAIT_RP -> IDLE.
//  Timing relative to transfer edge k (cycle k+1 = first cycle after the edge):
//   ACT0 k+1; ACT1 k+2; CAS0 k+1+T_RCD; CAS1 CAS0+1; PRE CAS0+T_RTP (read/fetch) or
//   CAS0+T_WTP (write); IDLE PRE+T_RP. The next ACT0 is no earlier than PRE+T_RP+1.
//  WAIT_* states are skipped when their residual count is 0 (T_RCD==2, T_xTP==2).
//  Counter: loaded with the residual on entering a wait; decrements; exits at 1. No wrap.
//  CAS kind (RD vs WR) comes from the latched opn: 1 -> WR0/WR1; 0 or 2 -> RD0/RD1.
//  opn==3: accepted, state stays IDLE, no command issued, err_illegal_op=1 for cycle k+1,
//   req_ready stays 1. Back-to-back illegal requests each produce their own pulse.
//  req_valid while busy: ignored. Upstream must hold the request; nothing is dropped or latched.
//  req_* changing while req_ready=0: no effect.
//  Reset mid-sequence: immediate return to reset values. The in-flight request is discarded
//   and no PRE is issued.
// CONFIGURATION
//  DDR5_CMD_TRACE_EN defined: adds a 64-bit cycle counter (reset 0, +1 per clk). Every
//   cmd_valid cycle writes one line via $display:
//   "At time <cyc> <ACT0|ACT1|RD0|RD1|WR0|WR1|PRE> <bg> <ba> <row|col>".
//   ACT lines print the row, RD/WR lines the column, PRE lines omit the address.
//  DDR5_CMD_TRACE_EN undefined: no counter and no system tasks; the logic is purely synthesizable.
//  Port list and cycle behaviour are identical in both builds.
// TESTING
//  Read with defaults: opn=0, bg=5, ba=2, row=16'hBEEF, col=10'h3A5, transfer edge 0.
//   Expected: ACT0@1, ACT1@2, RD0@9, RD1@10, PRE@15, req_ready=1@23; cmd_row=BEEF, cmd_col=3A5.
//  Write opn=1, transfer edge 0: ACT0@1, ACT1@2, WR0@9, WR1@10, PRE@21, req_ready=1@29.
//  Fetch opn=2: identical to the read case. Illegal opn=3: err_illegal_op=1@1 only,
//   cmd_valid=0 throughout, busy=0.
//  Backpressure: req_valid held high with a 2nd read during the 1st read.
//   Expected: 2nd transfer at edge 23, ACT0@24; no duplicated or lost command.
//  Reset: rst_n low at cycle 5 (WAIT_RCD). Expected: cmd_valid=0 and busy=0 the same cycle,
//   no RD0/PRE afterwards, req_ready=1 after release.
//  Corner timing: T_RCD=2, T_RTP=2, T_RP=1, opn=0.
//   Expected: ACT0@1, ACT1@2, RD0@3, RD1@4, PRE@5, req_ready=1@6.

Source files
------------

// File: rtl/ddr5_cmd_sequencer.sv
// ddr5_cmd_sequencer: closed-page DDR5 command sequencer, one request in flight.
// Emits ACT0,ACT1,RD0/WR0,RD1/WR1,PRE with tRCD, tRTP/tWTP and tRP spacing.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_opn/bg/ba/row/col decoded request (opn 0 rd, 1 wr, 2 fetch, 3 illegal)
//   cmd_valid/cmd_type    Moore command strobe and encoding
//   cmd_bg/ba/row/col     address fields latched at the last transfer
//   busy                  sequencer not IDLE
//   err_illegal_op        one-cycle pulse after an opn==3 request is dropped
//
// Optional build macro DDR5_CMD_TRACE_EN: adds a cycle counter and prints
// one trace line per issued command.
`timescale 1ns/1ps

module ddr5_cmd_sequencer #(
    parameter int T_RCD = 8,
    parameter int T_RTP = 6,
    parameter int T_WTP = 12,
    parameter int T_RP  = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_opn,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        busy,
    output logic        err_illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT0,
        S_ACT1,
        S_WAIT_RCD,
        S_CAS0,
        S_CAS1,
        S_WAIT_PRE,
        S_PRE,
        S_WAIT_RP
    } state_t;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ACT0 = 3'd1;
    localparam logic [2:0] C_ACT1 = 3'd2;
    localparam logic [2:0] C_RD0  = 3'd3;
    localparam logic [2:0] C_RD1  = 3'd4;
    localparam logic [2:0] C_WR0  = 3'd5;
    localparam logic [2:0] C_WR1  = 3'd6;
    localparam logic [2:0] C_PRE  = 3'd7;

    // Residual wait lengths: the cycles not already covered by the
    // command states themselves (ACT0/ACT1, CAS0/CAS1, PRE).
    localparam logic [CNT_W-1:0] RES_RCD = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] RES_RTP = CNT_W'(T_RTP - 2);
    localparam logic [CNT_W-1:0] RES_WTP = CNT_W'(T_WTP - 2);
    localparam logic [CNT_W-1:0] RES_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_pre_res;
    logic             r_is_wr;
    logic             r_err;
    logic             w_xfer;
    logic             w_legal;

    // Gated by rst_n so nothing is accepted while reset is held.
    assign req_ready      = (r_state == S_IDLE) && rst_n;
    assign w_xfer         = req_valid && req_ready;
    assign w_legal        = (req_opn != 2'd3);
    assign w_pre_res      = r_is_wr ? RES_WTP : RES_RTP;
    assign busy           = (r_state != S_IDLE);
    assign err_illegal_op = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_bg  <= '0;
            cmd_ba  <= '0;
            cmd_row <= '0;
            cmd_col <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_xfer && !w_legal;
            if (w_xfer) begin
                cmd_bg  <= req_bg;
                cmd_ba  <= req_ba;
                cmd_row <= req_row;
                cmd_col <= req_col;
                r_is_wr <= (req_opn == 2'd1);
            end
        end
    end

    // Next state and wait counter. A wait state is entered with its
    // residual loaded and left when the counter reaches 1; a zero
    // residual skips the wait state entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer && w_legal) begin
                    w_state_nxt = S_ACT0;
                end
            end
            S_ACT0: w_state_nxt = S_ACT1;
            S_ACT1: begin
                if (RES_RCD == '0) begin
                    w_state_nxt = S_CAS0;
                end else begin
                    w_state_nxt = S_WAIT_RCD;
                    w_cnt_nxt   = RES_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_CAS0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_CAS0: w_state_nxt = S_CAS1;
            S_CAS1: begin
                if (w_pre_res == '0) begin
                    w_state_nxt = S_PRE;
                end else begin
                    w_state_nxt = S_WAIT_PRE;
                    w_cnt_nxt   = w_pre_res;
                end
            end
            S_WAIT_PRE: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_PRE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_PRE: begin
                if (RES_RP == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_RP;
                    w_cnt_nxt   = RES_RP;
                end
            end
            S_WAIT_RP: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore command decode from the registered state.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_type  = C_NOP;
        unique case (r_state)
            S_ACT0: begin
                cmd_valid = 1'b1;
                cmd_type  = C_ACT0;
            end
            S_ACT1: begin
                cmd_valid = 1'b1;
                cmd_type  = C_ACT1;
            end
            S_CAS0: begin
                cmd_valid = 1'b1;
                cmd_type  = r_is_wr ? C_WR0 : C_RD0;
            end
            S_CAS1: begin
                cmd_valid = 1'b1;
                cmd_type  = r_is_wr ? C_WR1 : C_RD1;
            end
            S_PRE: begin
                cmd_valid = 1'b1;
                cmd_type  = C_PRE;
            end
            default: begin
                cmd_valid = 1'b0;
                cmd_type  = C_NOP;
            end
        endcase
    end

`ifdef DDR5_CMD_TRACE_EN
    logic [63:0] r_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && cmd_valid) begin
            unique case (cmd_type)
                C_ACT0: $display("At time %0d ACT0 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_row);
                C_ACT1: $display("At time %0d ACT1 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_row);
                C_RD0:  $display("At time %0d RD0 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_col);
                C_RD1:  $display("At time %0d RD1 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_col);
                C_WR0:  $display("At time %0d WR0 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_col);
                C_WR1:  $display("At time %0d WR1 %0d %0d %h",
                                 r_cyc, cmd_bg, cmd_ba, cmd_col);
                C_PRE:  $display("At time %0d PRE %0d %0d",
                                 r_cyc, cmd_bg, cmd_ba);
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// tb_ddr5_cmd_sequencer: scoreboard bench for ddr5_cmd_sequencer.
// DUT a uses default timing, DUT b the minimum legal timing.
`timescale 1ns/1ps

module tb_ddr5_cmd_sequencer;

    localparam int A_RCD = 8;
    localparam int A_RTP = 6;
    localparam int A_WTP = 12;
    localparam int A_RP  = 8;
    localparam int B_RCD = 2;
    localparam int B_RTP = 2;
    localparam int B_WTP = 2;
    localparam int B_RP  = 1;

    typedef struct {
        int          cyc;
        logic [2:0]  typ;
        logic [30:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid, a_rdy, a_cv, a_busy, a_err;
    logic [1:0]  a_opn, a_ba, a_cba;
    logic [2:0]  a_bg, a_ct, a_cbg;
    logic [15:0] a_row, a_crow;
    logic [9:0]  a_col, a_ccol;

    logic        b_valid, b_rdy, b_cv, b_busy, b_err;
    logic [1:0]  b_opn, b_ba, b_cba;
    logic [2:0]  b_bg, b_ct, b_cbg;
    logic [15:0] b_row, b_crow;
    logic [9:0]  b_col, b_ccol;

    ddr5_cmd_sequencer u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_rdy),
        .req_opn(a_opn), .req_bg(a_bg), .req_ba(a_ba),
        .req_row(a_row), .req_col(a_col),
        .cmd_valid(a_cv), .cmd_type(a_ct),
        .cmd_bg(a_cbg), .cmd_ba(a_cba),
        .cmd_row(a_crow), .cmd_col(a_ccol),
        .busy(a_busy), .err_illegal_op(a_err)
    );

    ddr5_cmd_sequencer #(
        .T_RCD(B_RCD), .T_RTP(B_RTP), .T_WTP(B_WTP), .T_RP(B_RP)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_rdy),
        .req_opn(b_opn), .req_bg(b_bg), .req_ba(b_ba),
        .req_row(b_row), .req_col(b_col),
        .cmd_valid(b_cv), .cmd_type(b_ct),
        .cmd_bg(b_cbg), .cmd_ba(b_cba),
        .cmd_row(b_crow), .cmd_col(b_ccol),
        .busy(b_busy), .err_illegal_op(b_err)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   ra[$];
    int   rb[$];
    int   ea[$];
    int   xa[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   ecnt  = 0;
    logic rst_p = 1'b0;
    logic a_rdy_p = 1'b0;
    logic b_rdy_p = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, ecnt);
        end
    endtask

    // Expected command stream for a transfer on edge k; the first cycle
    // after that edge is cycle k in this bench's numbering.
    task automatic push_seq(input int d, input int k, input logic [1:0] opn,
                            input logic [2:0] bg, input logic [1:0] ba,
                            input logic [15:0] row, input logic [9:0] col);
        int   rcd, tp, rp;
        logic wr;
        exp_t s[5];
        if (opn == 2'd3) begin
            if (d == 0) ea.push_back(k);
            return;
        end
        wr  = (opn == 2'd1);
        rcd = (d == 0) ? A_RCD : B_RCD;
        rp  = (d == 0) ? A_RP : B_RP;
        if (wr) tp = (d == 0) ? A_WTP : B_WTP;
        else    tp = (d == 0) ? A_RTP : B_RTP;
        s[0] = '{k, 3'd1, {bg, ba, row, col}};
        s[1] = '{k + 1, 3'd2, {bg, ba, row, col}};
        s[2] = '{k + rcd, wr ? 3'd5 : 3'd3, {bg, ba, row, col}};
        s[3] = '{k + rcd + 1, wr ? 3'd6 : 3'd4, {bg, ba, row, col}};
        s[4] = '{k + rcd + tp, 3'd7, {bg, ba, row, col}};
        for (int i = 0; i < 5; i++) begin
            if (d == 0) qa.push_back(s[i]);
            else        qb.push_back(s[i]);
        end
        if (d == 0) ra.push_back(k + rcd + tp + rp);
        else        rb.push_back(k + rcd + tp + rp);
    endtask

    task automatic mon_cmd(input int d, input logic [2:0] t,
                           input logic [30:0] addr);
        exp_t e;
        if (d == 0) begin
            if (qa.size() == 0) begin
                chk("a_cmd_unexpected", {1'b1, t}, 0);
                return;
            end
            e = qa.pop_front();
        end else begin
            if (qb.size() == 0) begin
                chk("b_cmd_unexpected", {1'b1, t}, 0);
                return;
            end
            e = qb.pop_front();
        end
        chk(d == 0 ? "a_cmd_cycle" : "b_cmd_cycle", ecnt, e.cyc);
        chk(d == 0 ? "a_cmd_type" : "b_cmd_type", t, e.typ);
        chk(d == 0 ? "a_cmd_addr" : "b_cmd_addr", addr, e.addr);
    endtask

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_rdy) begin
                xa.push_back(ecnt + 1);
                push_seq(0, ecnt + 1, a_opn, a_bg, a_ba, a_row, a_col);
            end
            if (b_valid && b_rdy)
                push_seq(1, ecnt + 1, b_opn, b_bg, b_ba, b_row, b_col);
            if (a_cv) mon_cmd(0, a_ct, {a_cbg, a_cba, a_crow, a_ccol});
            if (b_cv) mon_cmd(1, b_ct, {b_cbg, b_cba, b_crow, b_ccol});
            if (a_err) begin
                if (ea.size() == 0) chk("a_err_unexpected", 1, 0);
                else chk("a_err_cycle", ecnt, ea.pop_front());
            end
            if (b_err) chk("b_err_unexpected", 1, 0);
            if (rst_p && a_rdy && !a_rdy_p) begin
                if (ra.size() == 0) chk("a_ready_unexpected", 1, 0);
                else chk("a_ready_cycle", ecnt, ra.pop_front());
            end
            if (rst_p && b_rdy && !b_rdy_p) begin
                if (rb.size() == 0) chk("b_ready_unexpected", 1, 0);
                else chk("b_ready_cycle", ecnt, rb.pop_front());
            end
        end
        rst_p   <= rst_n;
        a_rdy_p <= a_rdy;
        b_rdy_p <= b_rdy;
    end

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input int d, input logic [1:0] opn,
                        input logic [2:0] bg, input logic [1:0] ba,
                        input logic [15:0] row, input logic [9:0] col);
        bit ok;
        ok = 1'b0;
        if (d == 0) begin
            a_valid = 1'b1; a_opn = opn; a_bg = bg;
            a_ba = ba; a_row = row; a_col = col;
        end else begin
            b_valid = 1'b1; b_opn = opn; b_bg = bg;
            b_ba = ba; b_row = row; b_col = col;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((d == 0) ? a_rdy : b_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (d == 0) begin
            a_valid = 1'b0; a_opn = 2'($urandom); a_bg = 3'($urandom);
            a_ba = 2'($urandom); a_row = 16'($urandom); a_col = 10'($urandom);
        end else begin
            b_valid = 1'b0; b_opn = 2'($urandom); b_bg = 3'($urandom);
            b_ba = 2'($urandom); b_row = 16'($urandom); b_col = 10'($urandom);
        end
    endtask

    task automatic wait_idle();
        int left;
        left = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            left = qa.size() + qb.size() + ra.size() + rb.size() + ea.size();
            if (left == 0) break;
        end
        chk("drain_pending", left, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_opn = '0; a_bg = '0; a_ba = '0; a_row = '0; a_col = '0;
        b_valid = 1'b0; b_opn = '0; b_bg = '0; b_ba = '0; b_row = '0; b_col = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", a_cv, 0);
        chk("rst_cmd_type", a_ct, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_fields", {a_cbg, a_cba, a_crow, a_ccol}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", a_rdy, 1);
        @(posedge clk);
        #1;

        send(0, 2'd0, 3'd5, 2'd2, 16'hBEEF, 10'h3A5);
        wait_idle();
        chk("hold_row", a_crow, 16'hBEEF);
        chk("hold_col", a_ccol, 10'h3A5);

        send(0, 2'd1, 3'd1, 2'd3, 16'h1234, 10'h0F0);
        wait_idle();

        send(0, 2'd2, 3'd7, 2'd0, 16'hA55A, 10'h201);
        wait_idle();

        send(0, 2'd3, 3'd2, 2'd1, 16'h0BAD, 10'h111);
        chk("ill_busy", a_busy, 0);
        chk("ill_ready", a_rdy, 1);
        chk("ill_pulse", a_err, 1);
        send(0, 2'd3, 3'd4, 2'd2, 16'h0BAE, 10'h112);
        wait_idle();

        xa.delete();
        send(0, 2'd0, 3'd3, 2'd1, 16'h1111, 10'h011);
        send(0, 2'd0, 3'd6, 2'd2, 16'h2222, 10'h022);
        chk("bp_transfers", xa.size(), 2);
        if (xa.size() >= 2) chk("bp_gap", xa[1] - xa[0], 23);
        wait_idle();

        send(0, 2'd0, 3'd2, 2'd3, 16'hCAFE, 10'h155);
        repeat (4) @(posedge clk);
        #1;
        chk("rcd_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_valid", a_cv, 0);
        chk("mid_rst_busy", a_busy, 0);
        qa.delete();
        ra.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", a_rdy, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_busy", a_busy, 0);

        send(1, 2'd0, 3'd6, 2'd1, 16'h7777, 10'h2AA);
        wait_idle();
        send(1, 2'd1, 3'd0, 2'd3, 16'h8888, 10'h155);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
